// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Synthesizable instruction-memory loader. It takes a byte stream, assembles
// big-endian 32-bit words and writes them through the instruction memory's
// word write port. The CPU is held in reset until a complete, well-formed
// image has been written.
//
// Frame: LEN_HI, LEN_LO (LEN = 16-bit word count), 4*LEN data bytes and, when
// IMEM_LOADER_CHECKSUM_EN is defined, one trailing checksum byte. With the
// checksum, the 8-bit sum of every accepted byte (length, data and checksum)
// must be 0.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//
// Parameters
//   ADDR_WIDTH  byte-address width of the instruction memory (valid 3..18);
//               capacity is 2^(ADDR_WIDTH-2) words.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   in_data    in   stream byte
//   in_valid   in   in_data is valid
//   in_ready   out  loader accepts a byte this cycle
//   mem_we     out  one-cycle word-write strobe
//   mem_addr   out  byte address of the written word (multiple of 4)
//   mem_wdata  out  written word, first stream byte in [31:24]
//   cpu_hold   out  keeps the CPU in reset while high
//   done       out  image loaded successfully (terminal)
//   error      out  image rejected (terminal)
// ----------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   // One extra bit over the word index so LEN == capacity is representable.
   localparam int          WCNT_W    = ADDR_WIDTH - 1;
   localparam int unsigned CAP_WORDS = 1 << (ADDR_WIDTH - 2);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK,
`else
      // Final mem_we cycle; completion is only signalled after the last
      // word has actually been presented to the memory.
      S_FLUSH,
`endif
      S_DONE,
      S_ERROR
   } state_t;

   state_t                  state_q;
   logic [7:0]              len_hi_q;
   logic [WCNT_W-1:0]       len_q;
   logic [WCNT_W-1:0]       wcnt_q;
   logic [1:0]              bcnt_q;
   logic [23:0]             shift_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]              sum_q;
   logic [7:0]              sum_d;
`endif

   logic                    in_ready_q;
   logic                    mem_we_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [31:0]             mem_wdata_q;
   logic                    cpu_hold_q;
   logic                    done_q;
   logic                    error_q;

   logic                    xfer;
   logic [15:0]             len_d;
   logic                    len_ok;
   logic                    last_word;
   logic [ADDR_WIDTH-1:0]   word_addr;

   always_comb begin
      // NOTE: every combinational output gets a value before any branch so
      // no path leaves it unassigned and no latch is inferred.
      xfer      = in_valid && in_ready_q;
      len_d     = {len_hi_q, in_data};
      len_ok    = (32'(len_d) <= CAP_WORDS);
      last_word = (wcnt_q == len_q - WCNT_W'(1));
      word_addr = {wcnt_q[ADDR_WIDTH-3:0], 2'b00};
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d     = sum_q + in_data;
`endif
   end

   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q     <= S_LEN_HI;
         len_hi_q    <= '0;
         len_q       <= '0;
         wcnt_q      <= '0;
         bcnt_q      <= '0;
         shift_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
         in_ready_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         // Strobe defaults low so it lasts exactly one cycle per word.
         mem_we_q <= 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
         if (xfer) begin
            sum_q <= sum_d;
         end
`endif

         unique case (state_q)
            S_LEN_HI: begin
               if (xfer) begin
                  len_hi_q <= in_data;
                  state_q  <= S_LEN_LO;
               end
            end

            S_LEN_LO: begin
               if (xfer) begin
                  len_q  <= WCNT_W'(len_d);
                  wcnt_q <= '0;
                  bcnt_q <= '0;
                  if (!len_ok) begin
                     // Rejected before any write, so addresses never wrap.
                     state_q    <= S_ERROR;
                     in_ready_q <= 1'b0;
                     error_q    <= 1'b1;
                  end else if (len_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_q    <= S_CHECK;
`else
                     state_q    <= S_DONE;
                     in_ready_q <= 1'b0;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
`endif
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (xfer) begin
                  bcnt_q  <= bcnt_q + 2'd1;
                  shift_q <= {shift_q[15:0], in_data};
                  if (bcnt_q == 2'd3) begin
                     // Earlier bytes sit higher in the word (big-endian).
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= word_addr;
                     mem_wdata_q <= {shift_q, in_data};
                     wcnt_q      <= wcnt_q + WCNT_W'(1);
                     if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q    <= S_CHECK;
`else
                        state_q    <= S_FLUSH;
                        in_ready_q <= 1'b0;
`endif
                     end
                  end
               end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (xfer) begin
                  in_ready_q <= 1'b0;
                  if (sum_d == 8'd0) begin
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                  end else begin
                     state_q <= S_ERROR;
                     error_q <= 1'b1;
                  end
               end
            end
`else
            S_FLUSH: begin
               state_q    <= S_DONE;
               done_q     <= 1'b1;
               cpu_hold_q <= 1'b0;
            end
`endif

            // S_DONE and S_ERROR are terminal; only reset leaves them.
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Frames are built with random data, a
// frame-level model derives the expected word writes and final outcome, and
// a monitor records every mem_we cycle for comparison.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

   localparam int AW  = 10;
   localparam int CAP = 1 << (AW - 2);

   typedef logic [7:0] byte_q_t [$];
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic [7:0]    in_data  = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          error;

   int     n_cmp = 0;
   int     n_bad = 0;
   longint cyc   = 0;

   wr_t    got_q [$];
   longint got_c [$];
   longint done_c = -1;
   wr_t    exp_q [$];
   bit     exp_done;
   bit     exp_err;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we) begin
         got_q.push_back(wr_t'{addr: mem_addr, data: mem_wdata});
         got_c.push_back(cyc);
      end
      if (done && done_c < 0) done_c = cyc;
   end

   // ---------------------------------------------------------------- model
   function automatic byte_q_t with_chk(input byte_q_t fr);
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0] s = 8'd0;
      foreach (fr[i]) s = s + fr[i];
      fr.push_back(~s + 8'd1);
`endif
      return fr;
   endfunction

   function automatic byte_q_t make_frame(input int len);
      byte_q_t fr;
      fr.push_back(8'(len >> 8));
      fr.push_back(8'(len));
      if (len <= CAP) begin
         for (int i = 0; i < 4 * len; i++) fr.push_back(8'($urandom));
         fr = with_chk(fr);
      end
      return fr;
   endfunction

   function automatic void model(input byte_q_t fr);
      int len;
      exp_q.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      len = int'({fr[0], fr[1]});
      if (len > CAP) begin
         exp_err = 1'b1;
         return;
      end
      for (int k = 0; k < len; k++)
         exp_q.push_back(wr_t'{addr: AW'(4 * k),
                               data: {fr[4*k+2], fr[4*k+3], fr[4*k+4], fr[4*k+5]}});
`ifdef IMEM_LOADER_CHECKSUM_EN
      begin
         logic [7:0] s = 8'd0;
         foreach (fr[i]) s = s + fr[i];
         exp_done = (s == 8'd0);
         exp_err  = !exp_done;
      end
`else
      exp_done = 1'b1;
`endif
   endfunction

   // Index of the first differing write, or -1 when the lists agree.
   function automatic int first_diff();
      int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (got_q[i] !== exp_q[i]) return i;
      if (got_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   // ------------------------------------------------------------- drivers
   task automatic clear_mon();
      got_q.delete();
      got_c.delete();
      done_c = -1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_mon();
   endtask

   // Called and returns on a falling edge; the byte has transferred on the
   // rising edge just before return when ok is set.
   task automatic send_byte(input logic [7:0] b, output bit ok);
      bit hs;
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      do begin
         hs = in_ready;
         @(posedge clk);
         @(negedge clk);
         n++;
      end while (!hs && n < 20);
      ok = hs;
   endtask

   task automatic send_frame(input byte_q_t fr, input int gap_pct, output bit ok);
      bit b_ok;
      ok = 1'b1;
      foreach (fr[i]) begin
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(3, 1)) @(negedge clk);
         end
         send_byte(fr[i], b_ok);
         if (!b_ok) begin
            ok = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_end(output bit ok);
      int n = 0;
      while (!(done || error) && n < 40) begin
         @(negedge clk);
         n++;
      end
      ok = done || error;
      @(negedge clk);
   endtask

   // --------------------------------------------------------------- tests
   task automatic test_reset();
      logic [AW+37:0] exp_v, got_v;
      do_reset();
      exp_v = {1'b1, 1'b0, {AW{1'b0}}, 32'd0, 1'b1, 1'b0, 1'b0};
      got_v = {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error};
      n_cmp++;
      if (got_v !== exp_v) begin
         n_bad++;
         $display("FAIL reset_state: got %h expected %h", got_v, exp_v);
      end
   endtask

   task automatic test_spec_vector();
      byte_q_t fr = '{8'h00, 8'h02, 8'h02, 8'h10, 8'h80, 8'h42,
                      8'h00, 8'h08, 8'h8A, 8'h42};
      bit ok, ok2;
      int d;
      do_reset();
      fr = with_chk(fr);
      model(fr);
      send_frame(fr, 0, ok);
      wait_end(ok2);
      n_cmp++;
      if (!(ok && ok2)) begin
         n_bad++;
         $display("FAIL spec_vec_timeout: sent %0d ended %0d required 1 1", ok, ok2);
      end
      d = first_diff();
      n_cmp++;
      if (d >= 0) begin
         n_bad++;
         $display("FAIL spec_vec_writes: diff at %0d, got %0d writes, expected %0d", d, got_q.size(), exp_q.size());
      end
      n_cmp++;
      if (got_q.size() == 2 && got_q[1] !== wr_t'{addr: AW'(4), data: 32'h00088A42}) begin
         n_bad++;
         $display("FAIL spec_vec_word1: got %h expected %h", got_q[1], wr_t'{addr: AW'(4), data: 32'h00088A42});
      end
      n_cmp++;
      if (got_c.size() == 0 || done_c !== got_c[got_c.size()-1] + 1) begin
         n_bad++;
         $display("FAIL spec_vec_done_cycle: got %0d expected one after last write", done_c);
      end
      n_cmp++;
      if ({done, error, cpu_hold, in_ready} !== {exp_done, exp_err, !exp_done, 1'b0}) begin
         n_bad++;
         $display("FAIL spec_vec_status: got %b expected %b", {done, error, cpu_hold, in_ready}, {exp_done, exp_err, !exp_done, 1'b0});
      end
   endtask

   // Continues from the finished state left by the previous test.
   task automatic test_ignore_after_done();
      clear_mon();
      in_valid = 1'b1;
      repeat (8) begin
         in_data = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (got_q.size() != 0 || {done, error, cpu_hold, in_ready} !== 4'b1000) begin
         n_bad++;
         $display("FAIL ignore_done: got %0d writes status %b expected 0 writes status 1000", got_q.size(), {done, error, cpu_hold, in_ready});
      end
   endtask

   task automatic test_len_zero();
      byte_q_t fr = '{8'h00, 8'h00};
      bit ok;
      do_reset();
      fr = with_chk(fr);
      model(fr);
      send_frame(fr, 0, ok);
      n_cmp++;
      if (!ok || done !== 1'b1 || cpu_hold !== 1'b0) begin
         n_bad++;
         $display("FAIL len_zero_done: sent %0d done %b hold %b expected 1 1 0", ok, done, cpu_hold);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL len_zero_writes: got %0d expected %0d", got_q.size(), exp_q.size());
      end
   endtask

   task automatic test_oversize();
      byte_q_t fr = make_frame(CAP + 1);
      bit ok;
      do_reset();
      model(fr);
      send_frame(fr, 0, ok);
      n_cmp++;
      if (!ok || {error, cpu_hold, in_ready, done} !== {exp_err, 1'b1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL oversize_status: sent %0d status %b expected 1 %b", ok, {error, cpu_hold, in_ready, done}, {exp_err, 1'b1, 1'b0, 1'b0});
      end
      in_valid = 1'b1;
      repeat (6) begin
         in_data = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (got_q.size() != 0 || error !== 1'b1 || in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL oversize_sticky: got %0d writes error %b ready %b expected 0 1 0", got_q.size(), error, in_ready);
      end
   endtask

   task automatic test_full_capacity();
      byte_q_t fr = make_frame(CAP);
      bit ok, ok2;
      int d;
      do_reset();
      model(fr);
      send_frame(fr, 0, ok);
      wait_end(ok2);
      d = first_diff();
      n_cmp++;
      if (!(ok && ok2) || d >= 0) begin
         n_bad++;
         $display("FAIL full_cap_writes: ok %0d%0d diff at %0d, got %0d expected %0d", ok, ok2, d, got_q.size(), exp_q.size());
      end
      n_cmp++;
      if (got_q.size() == 0 || got_q[got_q.size()-1].addr !== AW'('h3FC)) begin
         n_bad++;
         $display("FAIL full_cap_last_addr: got %h expected 3fc",
                  (got_q.size() == 0) ? {AW{1'bx}} : got_q[got_q.size()-1].addr);
      end
      n_cmp++;
      if ({done, error, cpu_hold} !== {exp_done, exp_err, !exp_done}) begin
         n_bad++;
         $display("FAIL full_cap_status: got %b expected %b", {done, error, cpu_hold}, {exp_done, exp_err, !exp_done});
      end
   endtask

   task automatic test_reset_midframe();
      byte_q_t part = '{8'h00, 8'h01, 8'hAA, 8'hBB};
      byte_q_t fr   = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      bit ok, ok2;
      do_reset();
      send_frame(part, 0, ok);
      do_reset();
      n_cmp++;
      if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b10100) begin
         n_bad++;
         $display("FAIL midframe_reset_state: got %b expected 10100", {in_ready, mem_we, cpu_hold, done, error});
      end
      fr = with_chk(fr);
      model(fr);
      send_frame(fr, 0, ok);
      wait_end(ok2);
      n_cmp++;
      if (!(ok && ok2) || got_q.size() != 1 ||
          got_q[0] !== wr_t'{addr: AW'(0), data: 32'hDEADBEEF} || done !== 1'b1) begin
         n_bad++;
         $display("FAIL midframe_rewrite: got %0d writes first %h done %b expected 1 write %h done 1",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : {(AW+32){1'bx}},
                  wr_t'{addr: AW'(0), data: 32'hDEADBEEF}, done);
      end
   endtask

   // The same frame with and without gaps must give identical writes.
   task automatic test_gaps();
      for (int it = 0; it < 4; it++) begin
         byte_q_t fr = make_frame($urandom_range(8, 1));
         wr_t     ref_q [$];
         bit ok, ok2;
         int d;
         do_reset();
         model(fr);
         send_frame(fr, 0, ok);
         wait_end(ok2);
         ref_q = got_q;
         do_reset();
         send_frame(fr, 50, ok);
         wait_end(ok2);
         d = first_diff();
         n_cmp++;
         if (!(ok && ok2) || d >= 0 || got_q != ref_q) begin
            n_bad++;
            $display("FAIL gaps_%0d: ok %0d%0d diff at %0d, got %0d writes, gapless %0d, expected %0d",
                     it, ok, ok2, d, got_q.size(), ref_q.size(), exp_q.size());
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int len = ($urandom_range(5) == 0) ? CAP + 1 + $urandom_range(30) : $urandom_range(12);
         byte_q_t fr = make_frame(len);
         bit ok, ok2;
         int d;
         do_reset();
         model(fr);
         send_frame(fr, 30, ok);
         wait_end(ok2);
         d = first_diff();
         n_cmp++;
         if (!(ok && ok2) || d >= 0 ||
             {done, error, cpu_hold, in_ready} !== {exp_done, exp_err, !exp_done, 1'b0}) begin
            n_bad++;
            $display("FAIL random_%0d len %0d: ok %0d%0d diff %0d writes %0d/%0d status %b expected %b",
                     it, len, ok, ok2, d, got_q.size(), exp_q.size(),
                     {done, error, cpu_hold, in_ready}, {exp_done, exp_err, !exp_done, 1'b0});
         end
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      byte_q_t good = with_chk('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78});
      byte_q_t bad  = good;
      bit ok, ok2;
      bad[bad.size()-1] = bad[bad.size()-1] + 8'd1;
      do_reset();
      model(good);
      send_frame(good, 0, ok);
      wait_end(ok2);
      n_cmp++;
      if (!(ok && ok2) || {done, error, cpu_hold} !== {exp_done, exp_err, !exp_done} || first_diff() >= 0) begin
         n_bad++;
         $display("FAIL chk_good: status %b expected %b writes %0d", {done, error, cpu_hold}, {exp_done, exp_err, !exp_done}, got_q.size());
      end
      do_reset();
      model(bad);
      send_frame(bad, 0, ok);
      wait_end(ok2);
      n_cmp++;
      if (!(ok && ok2) || {done, error, cpu_hold} !== {exp_done, exp_err, 1'b1} ||
          got_q.size() != 1 || got_q[0] !== wr_t'{addr: AW'(0), data: 32'h12345678}) begin
         n_bad++;
         $display("FAIL chk_bad: status %b expected %b writes %0d expected 1", {done, error, cpu_hold}, {exp_done, exp_err, 1'b1}, got_q.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_spec_vector();
      test_ignore_after_done();
      test_len_zero();
      test_oversize();
      test_full_capacity();
      test_reset_midframe();
      test_gaps();
      test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
